// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the DRAM request-port arbiter.
// Also provides the legacy `DRAMW / `DRAM_REQ_* macros for older CORE files.
`ifndef DRAMW
`define DRAMW 32
`endif
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'd1
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'd2
`endif

package dram_arbiter_pkg;

    localparam int DRAMW = 32;

    localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
    localparam logic [1:0] DRAM_REQ_READ  = 2'd1;
    localparam logic [1:0] DRAM_REQ_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_XFER  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after
// i_ptr, wrapping, returned both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path infers a latch.
        o_win   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_valid && i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_valid                          = 1'b1;
                o_win[(int'(i_ptr) + k) % NREQ] = 1'b1;
                o_idx                            = PW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Grants the single DRAM request port to NREQ requesters, one whole transfer
// per grant. Define DRAM_ARB_FIXPRI_EN for fixed priority (lowest index wins).
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DRAMW
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2*NREQ-1:0] R_REQ,
    input  logic [32*NREQ-1:0] R_INITADR,
    input  logic [32*NREQ-1:0] R_BLOCKS,
    input  logic [DW*NREQ-1:0] R_DIN,
    output logic [NREQ-1:0]   R_GNT,
    output logic [NREQ-1:0]   R_BUSY,
    output logic [NREQ-1:0]   R_DONE,
    output logic [NREQ-1:0]   R_W,
    output logic [NREQ-1:0]   R_DOUTEN,
    output logic [DW-1:0]     R_DOUT,
    output logic [1:0]        D_REQ,
    output logic [31:0]       D_INITADR,
    output logic [31:0]       D_ELEM,
    output logic [DW-1:0]     D_DIN,
    input  logic              D_BUSY,
    input  logic              D_W,
    input  logic              D_DOUTEN,
    input  logic [DW-1:0]     D_DOUT
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state, w_state_nxt;
    logic [PW-1:0]   r_owner, r_ptr, w_win_idx, w_ptr_nxt;
    logic [1:0]      r_kind;
    logic [31:0]     r_initadr, r_blocks, r_remain;
    logic [NREQ-1:0] w_req_vld, w_win, w_owner_oh;
    logic            w_any, w_take, w_beat;
    logic [1:0]      w_sel_code;
    logic [31:0]     w_sel_adr, w_sel_blocks;

    // Only READ/WRITE codes compete; code 3 is never granted.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            w_req_vld[i] = (R_REQ[2*i +: 2] == DRAM_REQ_READ) ||
                           (R_REQ[2*i +: 2] == DRAM_REQ_WRITE);
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req   (w_req_vld),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_any)
    );

    assign w_sel_code   = R_REQ[2*w_win_idx +: 2];
    assign w_sel_adr    = R_INITADR[32*w_win_idx +: 32];
    assign w_sel_blocks = R_BLOCKS[32*w_win_idx +: 32];
    assign w_take       = (r_state == ARB_IDLE) && !D_BUSY && w_any;
    assign w_beat       = (r_kind == DRAM_REQ_READ) ? D_DOUTEN : D_W;
    assign w_owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign D_DIN        = R_DIN[DW*r_owner +: DW];
    assign R_DOUT       = D_DOUT;

`ifdef DRAM_ARB_FIXPRI_EN
    assign w_ptr_nxt = '0;
`else
    assign w_ptr_nxt = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_take) w_state_nxt = (w_sel_blocks == '0) ? ARB_DONE : ARB_ISSUE;
            ARB_ISSUE: w_state_nxt = ARB_XFER;
            ARB_XFER:  if (r_remain == '0 || (w_beat && r_remain == 32'd1))
                           w_state_nxt = ARB_DONE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs are forced low while RST is held so reset clears them in the same cycle.
    always_comb begin
        R_GNT     = '0;
        R_BUSY    = '0;
        R_DONE    = '0;
        R_W       = '0;
        R_DOUTEN  = '0;
        D_REQ     = DRAM_REQ_NONE;
        D_INITADR = '0;
        D_ELEM    = '0;
        if (!RST) begin
            if (w_take) R_GNT = w_win;
            R_BUSY = R_GNT | ((r_state != ARB_IDLE) ? w_owner_oh : '0);
            case (r_state)
                ARB_ISSUE: begin
                    D_REQ     = r_kind;
                    D_INITADR = r_initadr;
                    D_ELEM    = r_blocks;
                end
                ARB_XFER: begin
                    if (D_W)      R_W      = w_owner_oh;
                    if (D_DOUTEN) R_DOUTEN = w_owner_oh;
                end
                ARB_DONE:  R_DONE = w_owner_oh;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_kind    <= DRAM_REQ_NONE;
            r_initadr <= '0;
            r_blocks  <= '0;
            r_remain  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner   <= w_win_idx;
                r_kind    <= w_sel_code;
                r_initadr <= w_sel_adr;
                r_blocks  <= w_sel_blocks;
                r_remain  <= w_sel_blocks;
            end else if (r_state == ARB_XFER && w_beat && r_remain != '0) begin
                r_remain <= r_remain - 32'd1;
            end
            if (r_state == ARB_DONE) r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter (NREQ=2): a per-cycle vector table for a
// single read, then hand sequences for arbitration order, write steering, zero-length and reset.
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [3:0]      r_req = '0;
    logic [63:0]     r_initadr = {32'h0000_0200, 32'h0000_0100};
    logic [63:0]     r_blocks = '0;
    logic [63:0]     r_din = '0;
    logic [1:0]      R_GNT, R_BUSY, R_DONE, R_W, R_DOUTEN, D_REQ;
    logic [DW-1:0]   R_DOUT, D_DIN;
    logic [31:0]     D_INITADR, D_ELEM;
    logic            D_BUSY = 1'b0, D_W = 1'b0, D_DOUTEN = 1'b0;
    logic [DW-1:0]   D_DOUT = '0;

    int n_vec = 0;
    int n_err = 0;

    dram_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .R_REQ(r_req), .R_INITADR(r_initadr), .R_BLOCKS(r_blocks),
        .R_DIN(r_din), .R_GNT(R_GNT), .R_BUSY(R_BUSY), .R_DONE(R_DONE), .R_W(R_W),
        .R_DOUTEN(R_DOUTEN), .R_DOUT(R_DOUT), .D_REQ(D_REQ), .D_INITADR(D_INITADR),
        .D_ELEM(D_ELEM), .D_DIN(D_DIN), .D_BUSY(D_BUSY), .D_W(D_W),
        .D_DOUTEN(D_DOUTEN), .D_DOUT(D_DOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] blk0;
        logic        dbusy, dw, den;
        logic [1:0]  gnt, bsy, done, rw, rden, dreq;
        logic [31:0] adr, elem;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        r_req = '0; D_W = 1'b0; D_DOUTEN = 1'b0; D_BUSY = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    function automatic logic [95:0] outs();
        return {R_GNT, R_BUSY, R_DONE, R_W, R_DOUTEN, D_REQ, D_INITADR, D_ELEM};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  got_bits;
        logic [31:0] mem [3];
        logic [31:0] wdata [3];
        int ng, beats, own, last_done, stray, seen;
        bit want0, want1;

        // req, blk0, dbusy, dw, den | gnt, bsy, done, rw, rden, dreq, adr, elem
        tbl[0]  = '{4'b0000, 32'd4, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // reset state
        tbl[1]  = '{4'b0011, 32'd4, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // code 3 ignored
        tbl[2]  = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // idle beat dropped
        tbl[3]  = '{4'b0001, 32'd4, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // D_BUSY blocks
        tbl[4]  = '{4'b0001, 32'd4, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // grant R0
        tbl[5]  = '{4'b0000, 32'd4, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 32'h100, 32'd4}; // issue read
        tbl[6]  = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'd0, 32'h0,   32'd0}; // beat 1
        tbl[7]  = '{4'b0000, 32'd4, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // gap
        tbl[8]  = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'd0, 32'h0,   32'd0}; // beat 2
        tbl[9]  = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'd0, 32'h0,   32'd0}; // beat 3
        tbl[10] = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'd0, 32'h0,   32'd0}; // beat 4
        tbl[11] = '{4'b0000, 32'd4, 0, 0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // done, extra beat ignored
        tbl[12] = '{4'b0000, 32'd4, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,   32'd0}; // back to idle

        do_reset();
        for (int i = 0; i < 13; i++) begin
            r_req = tbl[i].req; r_blocks[31:0] = tbl[i].blk0;
            D_BUSY = tbl[i].dbusy; D_W = tbl[i].dw; D_DOUTEN = tbl[i].den;
            @(negedge CLK);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].gnt, tbl[i].bsy, tbl[i].done, tbl[i].rw, tbl[i].rden,
                   tbl[i].dreq, tbl[i].adr, tbl[i].elem});
            @(posedge CLK); #1;
        end

        // Both requesters keep re-requesting 2-block reads; grant order and DONE->grant gap.
        do_reset();
        r_blocks = {32'd2, 32'd2};
        want0 = 1; want1 = 1; beats = 0; ng = 0; own = 0; last_done = 0; stray = 0;
        got_bits = '0;
        for (int cyc = 0; cyc < 120 && ng < 4; cyc++) begin
            r_req = {want1 ? DRAM_REQ_READ : DRAM_REQ_NONE, want0 ? DRAM_REQ_READ : DRAM_REQ_NONE};
            D_DOUTEN = (beats > 0);
            if (beats > 0) beats--;
            @(negedge CLK);
            if ((R_DOUTEN & ~(2'b01 << own)) != 2'b00) stray++;
            if (R_GNT != 2'b00) begin
                if (ng > 0) check("rr_turnaround", 128'(cyc - last_done), 128'd1);
                own = R_GNT[1] ? 1 : 0;
                got_bits[ng] = R_GNT[1];
                ng++;
                if (R_GNT[0]) want0 = 0;
                if (R_GNT[1]) want1 = 0;
            end
            if (R_DONE != 2'b00) last_done = cyc;
            if (R_DONE[0]) want0 = 1;
            if (R_DONE[1]) want1 = 1;
            if (D_REQ != DRAM_REQ_NONE) beats = int'(D_ELEM);
            @(posedge CLK); #1;
        end
        check("rr_grants", 128'(ng), 128'd4);
`ifdef DRAM_ARB_FIXPRI_EN
        check("rr_order", 128'(got_bits), 128'b0000);
`else
        check("rr_order", 128'(got_bits), 128'b1010);
`endif
        check("rr_stray_douten", 128'(stray), 128'd0);

        // R1 writes A,B,C; slice 0 carries junk that must never reach D_DIN.
        do_reset();
        wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC;
        r_blocks[63:32] = 32'd3;
        r_din = {32'h0, 32'hDEAD_0000};
        r_req = {DRAM_REQ_WRITE, DRAM_REQ_NONE};
        @(negedge CLK);
        check("wr_gnt", 128'(R_GNT), 128'(2'b10));
        @(posedge CLK); #1 r_req = '0;
        @(negedge CLK);
        check("wr_issue", {D_REQ, D_INITADR, D_ELEM}, {DRAM_REQ_WRITE, 32'h200, 32'd3});
        @(posedge CLK); #1;
        for (int k = 0; k < 3; k++) begin
            r_din[63:32] = wdata[k]; D_W = 1'b1;
            @(negedge CLK);
            check($sformatf("wr_strobe%0d", k), {R_W, R_DOUTEN}, {2'b10, 2'b00});
            mem[k] = D_DIN;
            @(posedge CLK); #1;
        end
        D_DOUT = 32'h55;
        @(negedge CLK);
        check("wr_done", {R_DONE, R_W, R_DOUT}, {2'b10, 2'b00, 32'h55});
        check("wr_mem", {mem[0], mem[1], mem[2]}, {32'hA, 32'hB, 32'hC});
        @(posedge CLK); #1 D_W = 1'b0;

        // Zero-length request: grant, then DONE straight away, never a command.
        r_blocks[31:0] = 32'd0;
        r_req = {DRAM_REQ_NONE, DRAM_REQ_READ};
        @(negedge CLK);
        check("zero_gnt", {R_GNT, D_REQ}, {2'b01, 2'd0});
        @(posedge CLK); #1 r_req = '0;
        @(negedge CLK);
        check("zero_done", {R_DONE, D_REQ}, {2'b01, 2'd0});
        @(posedge CLK); #1;
        @(negedge CLK);
        check("zero_idle", {R_BUSY, R_DONE, D_REQ}, 6'b0);

        // Reset during a 4-block read after one beat (pointer is 1 at this point).
        @(posedge CLK); #1;
        r_blocks[31:0] = 32'd4;
        r_req = {DRAM_REQ_NONE, DRAM_REQ_READ};
        @(negedge CLK);
        check("rst_pre_gnt", 128'(R_GNT), 128'(2'b01));
        @(posedge CLK); #1 r_req = '0;
        @(posedge CLK); #1 D_DOUTEN = 1'b1;
        @(negedge CLK);
        check("rst_pre_beat", 128'(R_DOUTEN), 128'(2'b01));
        @(posedge CLK); #1 RST = 1'b1;
        #1 check("rst_outs", outs(), 96'h0);
        seen = 0;
        @(posedge CLK); #1 RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (R_DONE != 2'b00 || R_DOUTEN != 2'b00 || R_BUSY != 2'b00) seen++;
            @(posedge CLK); #1;
        end
        check("rst_no_done", 128'(seen), 128'd0);
        D_DOUTEN = 1'b0;
        r_blocks = {32'd2, 32'd2};
        r_req = {DRAM_REQ_READ, DRAM_REQ_READ};
        @(negedge CLK);
        check("rst_ptr_zero", 128'(R_GNT), 128'(2'b01));
        @(posedge CLK); #1 r_req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
